seven_seg_scan: RTL

//   Display-side consumer of the four 8-bit digit patterns (LED0..LED3) built by the LED selection mux.

---
 rtl/seven_seg_scan_if.sv | 25 ++
 rtl/seven_seg_scan.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_if.sv
// Pattern/display bundle between the LED selection mux and the 7-segment scanner.
// Latency: none, wiring only.
// Backpressure: none; patterns are level signals and the display outputs are free-running.
interface seven_seg_scan_if;
    logic       enable;
    logic [7:0] LED0;
    logic [7:0] LED1;
    logic [7:0] LED2;
    logic [7:0] LED3;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_done;

    // Producer side: supplies enable and the four digit patterns, observes the display.
    modport master (
        output enable, LED0, LED1, LED2, LED3,
        input  an, seg, frame_done
    );

    // Scanner side.
    modport slave (
        input  enable, LED0, LED1, LED2, LED3,
        output an, seg, frame_done
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexes four 8-bit digit patterns onto one shared 4-digit 7-segment display.
// Latency: outputs registered; a new frame shows its first BLANK cycle one clock after enable is seen high.
// Backpressure: none; patterns are snapshotted once per frame, enable=0 blanks the display on the next clock.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seven_seg_scan_if.slave disp
);

    localparam int             CW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  DIV_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic [3:0]     AN_OFF     = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic [7:0]     SEG_OFF    = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // With no blanking gap every slot starts straight in DRIVE.
    localparam state_t SLOT_START = (BLANK_CYC == 0) ? DRIVE : BLANK;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   div_q, div_d;
    logic [3:0][7:0] shadow_q, shadow_d;
    logic [3:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic            fd_q, fd_d;
    logic [3:0]      lit_an;
    logic [7:0]      lit_seg;

    // Next-state, counters, snapshot and display outputs; outputs are derived from
    // the next state so the registered an/seg always match the registered state.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        fd_d     = 1'b0;
        lit_an   = 4'h0;
        lit_seg  = 8'h00;

        if (!disp.enable) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            div_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SLOT_START;
                    idx_d    = 2'd0;
                    div_d    = '0;
                    shadow_d = {disp.LED3, disp.LED2, disp.LED1, disp.LED0};
                end
                BLANK: begin
                    div_d = div_q + 1'b1;
                    if (div_q == BLANK_LAST) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        state_d = SLOT_START;
                        // End of digit 3 closes the frame: fresh snapshot for the next one.
                        if (idx_q == 2'd3) begin
                            shadow_d = {disp.LED3, disp.LED2, disp.LED1, disp.LED0};
                            fd_d     = 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    div_d   = '0;
                end
            endcase
        end

        if (state_d == DRIVE) begin
            lit_an  = 4'(4'b0001 << idx_d);
            lit_seg = shadow_d[idx_d];
        end
        an_d  = (ACTIVE_LOW != 0) ? ~lit_an  : lit_an;
        seg_d = (ACTIVE_LOW != 0) ? ~lit_seg : lit_seg;
    end

    // State, counters, snapshot and output registers; reset forces the display dark at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            div_q    <= '0;
            shadow_q <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign disp.an         = an_q;
    assign disp.seg        = seg_q;
    assign disp.frame_done = fd_q;

endmodule
